// File: rtl/alu_pkg.sv
// Shared ALU op codes, port ids and widths for the ALU arbiter slice.
package alu_pkg;

    localparam int ALU_OP_W = 3;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_SUB = 3'b110,
        ALU_SLT = 3'b111
    } alu_op_e;

    localparam logic PORT_EX  = 1'b0;
    localparam logic PORT_AUX = 1'b1;

endpackage

// File: rtl/alu_arbiter_if.sv
// Two requester ports, the shared-ALU drive/return, and the tagged response.
interface alu_arbiter_if #(
    parameter int WIDTH = 32
);
    import alu_pkg::*;

    logic                req0;
    logic [WIDTH-1:0]    a0;
    logic [WIDTH-1:0]    b0;
    logic [ALU_OP_W-1:0] op0;
    logic                gnt0;

    logic                req1;
    logic [WIDTH-1:0]    a1;
    logic [WIDTH-1:0]    b1;
    logic [ALU_OP_W-1:0] op1;
    logic                gnt1;

    logic [WIDTH-1:0]    alu_a;
    logic [WIDTH-1:0]    alu_b;
    logic [ALU_OP_W-1:0] alu_op;
    logic [WIDTH-1:0]    alu_result;
    logic                alu_zero;
    logic                alu_overflow;
    logic                alu_set;

    logic                rsp_valid;
    logic                rsp_id;
    logic [WIDTH-1:0]    rsp_result;
    logic                rsp_zero;
    logic                rsp_overflow;
    logic                rsp_set;

    modport master (
        output req0, a0, b0, op0, req1, a1, b1, op1,
        output alu_result, alu_zero, alu_overflow, alu_set,
        input  gnt0, gnt1, alu_a, alu_b, alu_op,
        input  rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_overflow, rsp_set
    );

    modport slave (
        input  req0, a0, b0, op0, req1, a1, b1, op1,
        input  alu_result, alu_zero, alu_overflow, alu_set,
        output gnt0, gnt1, alu_a, alu_b, alu_op,
        output rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_overflow, rsp_set
    );

endinterface

// File: rtl/alu_arbiter.sv
// Two-port arbiter for one shared ALU: port 0 priority, port 1 forced after STARVE_LIMIT denials.
// Grant is combinational, tagged response registered 1 cycle later; no response backpressure.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 4
) (
    input logic          clk,
    input logic          rst,
    alu_arbiter_if.slave bus
);

    logic [CNT_W-1:0]    starve_cnt;
    logic                force1;
    logic                gnt0;
    logic                gnt1;
    logic [WIDTH-1:0]    alu_a;
    logic [WIDTH-1:0]    alu_b;
    logic [ALU_OP_W-1:0] alu_op;

    logic                rsp_valid;
    logic                rsp_id;
    logic [WIDTH-1:0]    rsp_result;
    logic                rsp_zero;
    logic                rsp_overflow;
    logic                rsp_set;

    assign force1 = (starve_cnt == CNT_W'(STARVE_LIMIT));

    // Reset gates the grants so nothing issued during reset can produce a response.
    assign gnt1 = ~rst & bus.req1 & (~bus.req0 | force1);
    assign gnt0 = ~rst & bus.req0 & ~gnt1;

    always_comb begin
        alu_a  = '0;
        alu_b  = '0;
        alu_op = ALU_AND;
        if (gnt0) begin
            alu_a  = bus.a0;
            alu_b  = bus.b0;
            alu_op = bus.op0;
        end else if (gnt1) begin
            alu_a  = bus.a1;
            alu_b  = bus.b1;
            alu_op = bus.op1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid    <= 1'b0;
            rsp_id       <= PORT_EX;
            rsp_result   <= '0;
            rsp_zero     <= 1'b0;
            rsp_overflow <= 1'b0;
            rsp_set      <= 1'b0;
            starve_cnt   <= '0;
        end else begin
            rsp_valid <= gnt0 | gnt1;
            if (gnt0 | gnt1) begin
                rsp_id       <= gnt1 ? PORT_AUX : PORT_EX;
                rsp_result   <= bus.alu_result;
                rsp_zero     <= bus.alu_zero;
                rsp_overflow <= bus.alu_overflow;
                rsp_set      <= bus.alu_set;
            end
            // Counts only while port 1 is actively being refused; a withdrawal restarts it.
            if (gnt1 || !bus.req1) begin
                starve_cnt <= '0;
            end else if (!force1) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

    assign bus.gnt0         = gnt0;
    assign bus.gnt1         = gnt1;
    assign bus.alu_a        = alu_a;
    assign bus.alu_b        = alu_b;
    assign bus.alu_op       = alu_op;
    assign bus.rsp_valid    = rsp_valid;
    assign bus.rsp_id       = rsp_id;
    assign bus.rsp_result   = rsp_result;
    assign bus.rsp_zero     = rsp_zero;
    assign bus.rsp_overflow = rsp_overflow;
    assign bus.rsp_set      = rsp_set;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: behavioural ALU, transaction-level arbitration model, directed + random tests.
module tb_alu_arbiter;
    import alu_pkg::*;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        r0, r1;
    logic [31:0] a0, b0, a1, b1;
    logic [2:0]  op0, op1;

    int total = 0;
    int bad   = 0;

    // model state: cycles port 1 has been refused, and the expected registered response
    int          m_wait;
    logic        m_vld;
    logic        m_id;
    logic [34:0] m_rsp;

    always #5 clk = ~clk;

    alu_arbiter_if #(.WIDTH(32)) bus ();

    alu_arbiter #(.WIDTH(32), .STARVE_LIMIT(LIMIT), .CNT_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.req0 = r0;
    assign bus.a0   = a0;
    assign bus.b0   = b0;
    assign bus.op0  = op0;
    assign bus.req1 = r1;
    assign bus.a1   = a1;
    assign bus.b1   = b1;
    assign bus.op1  = op1;

    // returns {zero, overflow, set, result}
    function automatic logic [34:0] alu_ref(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        logic        o, s;
        o = 1'b0;
        s = 1'b0;
        case (op)
            ALU_AND: r = a & b;
            ALU_OR:  r = a | b;
            ALU_ADD: begin r = a + b; o = (a[31] == b[31]) && (r[31] != a[31]); end
            ALU_SUB: begin r = a - b; o = (a[31] != b[31]) && (r[31] != a[31]); end
            ALU_SLT: begin s = ($signed(a) < $signed(b)); r = {31'd0, s}; end
            default: r = 32'd0;
        endcase
        return {(r == 32'd0), o, s, r};
    endfunction

    assign {bus.alu_zero, bus.alu_overflow, bus.alu_set, bus.alu_result} = alu_ref(bus.alu_op, bus.alu_a, bus.alu_b);

    logic [38:0] obs;
    assign obs = {bus.gnt0, bus.gnt1, bus.rsp_valid, bus.rsp_id,
                  bus.rsp_zero, bus.rsp_overflow, bus.rsp_set, bus.rsp_result};

    // {gnt0, gnt1}: port 1 wins if alone or after LIMIT refusals in a row
    function automatic logic [1:0] pick();
        logic w1;
        if (rst) return 2'b00;
        w1 = r1 && (!r0 || m_wait >= LIMIT);
        return {r0 && !w1, w1};
    endfunction

    function automatic logic [38:0] exp_vec();
        return {pick(), m_vld, m_id, m_rsp};
    endfunction

    function automatic void model_step();
        logic [1:0] g;
        g = pick();
        if (rst) begin
            m_vld  = 1'b0;
            m_id   = 1'b0;
            m_rsp  = '0;
            m_wait = 0;
        end else begin
            m_vld = g[1] | g[0];
            if (g[1]) begin m_id = 1'b0; m_rsp = alu_ref(op0, a0, b0); end
            if (g[0]) begin m_id = 1'b1; m_rsp = alu_ref(op1, a1, b1); end
            if (r1 && !g[0]) m_wait = (m_wait < LIMIT) ? m_wait + 1 : LIMIT;
            else             m_wait = 0;
        end
    endfunction

    task automatic advance();
        model_step();
        @(negedge clk);
    endtask

    function automatic logic [31:0] rand_opnd();
        case ($urandom_range(0, 3))
            0:       return 32'h7FFF_FFFF;
            1:       return 32'h8000_0000;
            2:       return 32'($urandom_range(0, 8));
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [2:0] rand_op();
        case ($urandom_range(0, 4))
            0:       return ALU_AND;
            1:       return ALU_OR;
            2:       return ALU_ADD;
            3:       return ALU_SUB;
            default: return ALU_SLT;
        endcase
    endfunction

    task automatic test_reset();
        rst = 1'b1; r0 = 1'b1; r1 = 1'b1;
        a0 = 32'd1; b0 = 32'd2; op0 = ALU_ADD;
        a1 = 32'd3; b1 = 32'd4; op1 = ALU_OR;
        @(negedge clk);
        model_step();
        for (int i = 0; i < 2; i++) begin
            #1;
            total++;
            if (obs !== exp_vec()) begin
                bad++; $display("FAIL reset_hold%0d: got %h want %h", i, obs, exp_vec());
            end
            total++;
            if ({bus.alu_a, bus.alu_b, bus.alu_op} !== 67'd0) begin
                bad++; $display("FAIL reset_alu_drive%0d: got %h/%h/%h want 0", i, bus.alu_a, bus.alu_b, bus.alu_op);
            end
            advance();
        end
        rst = 1'b0;
        #1;
        total++;
        if ({bus.gnt0, bus.gnt1} !== 2'b10) begin
            bad++; $display("FAIL reset_first_grant: got %b want 10", {bus.gnt0, bus.gnt1});
        end
        advance();
    endtask

    task automatic test_port0();
        r0 = 1'b1; r1 = 1'b0; a0 = 32'd5; b0 = 32'd3; op0 = ALU_SUB;
        #1;
        total++;
        if (obs !== exp_vec() || bus.gnt0 !== 1'b1) begin
            bad++; $display("FAIL port0_grant: got %h want %h", obs, exp_vec());
        end
        advance();
        r0 = 1'b0;
        #1;
        total++;
        if (obs !== exp_vec()) begin
            bad++; $display("FAIL port0_model: got %h want %h", obs, exp_vec());
        end
        total++;
        if ({bus.rsp_valid, bus.rsp_id, bus.rsp_zero, bus.rsp_result} !== {3'b100, 32'd2}) begin
            bad++; $display("FAIL port0_rsp: got v%b id%b z%b r%0d want v1 id0 z0 r2",
                            bus.rsp_valid, bus.rsp_id, bus.rsp_zero, bus.rsp_result);
        end
        advance();
    endtask

    task automatic test_port1();
        r1 = 1'b1; a1 = 32'd7; b1 = 32'd7; op1 = ALU_SUB;
        #1;
        total++;
        if (obs !== exp_vec() || bus.gnt1 !== 1'b1) begin
            bad++; $display("FAIL port1_grant: got %h want %h", obs, exp_vec());
        end
        advance();
        r1 = 1'b0;
        #1;
        total++;
        if ({bus.rsp_valid, bus.rsp_id, bus.rsp_zero, bus.rsp_result} !== {3'b111, 32'd0}) begin
            bad++; $display("FAIL port1_rsp: got v%b id%b z%b r%0d want v1 id1 z1 r0",
                            bus.rsp_valid, bus.rsp_id, bus.rsp_zero, bus.rsp_result);
        end
        advance();
    endtask

    task automatic test_contention();
        int seq[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        r0 = 1'b1; r1 = 1'b1;
        for (int i = 0; i < 11; i++) begin
            if (i == 10) begin r0 = 1'b0; r1 = 1'b0; end
            a0 = $urandom; b0 = $urandom; op0 = rand_op();
            a1 = $urandom; b1 = $urandom; op1 = rand_op();
            #1;
            total++;
            if (obs !== exp_vec()) begin
                bad++; $display("FAIL contention_model%0d: got %h want %h", i, obs, exp_vec());
            end
            if (i < 10) begin
                total++;
                if (bus.gnt1 !== (seq[i] == 1) || bus.gnt0 !== (seq[i] == 0)) begin
                    bad++; $display("FAIL contention_seq%0d: got g0=%b g1=%b want port %0d", i, bus.gnt0, bus.gnt1, seq[i]);
                end
            end
            if (i > 0) begin
                total++;
                if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== (seq[i-1] == 1)) begin
                    bad++; $display("FAIL contention_rsp%0d: got v%b id%b want v1 id%0d", i, bus.rsp_valid, bus.rsp_id, seq[i-1]);
                end
            end
            advance();
        end
    endtask

    task automatic test_withdraw();
        for (int i = 0; i < 11; i++) begin
            r0 = 1'b1;
            r1 = (i != 4 && i != 10);
            a0 = rand_opnd(); b0 = rand_opnd(); op0 = rand_op();
            a1 = rand_opnd(); b1 = rand_opnd(); op1 = rand_op();
            #1;
            total++;
            if (obs !== exp_vec()) begin
                bad++; $display("FAIL withdraw_model%0d: got %h want %h", i, obs, exp_vec());
            end
            if (i >= 4 && i <= 8) begin
                total++;
                if ({bus.gnt0, bus.gnt1} !== 2'b10) begin
                    bad++; $display("FAIL withdraw_gnt%0d: got %b want 10", i, {bus.gnt0, bus.gnt1});
                end
            end
            advance();
        end
        r0 = 1'b0; r1 = 1'b0;
        advance();
    endtask

    task automatic test_overflow();
        r0 = 1'b1; a0 = 32'h7FFF_FFFF; b0 = 32'd1; op0 = ALU_ADD;
        #1;
        advance();
        r0 = 1'b0;
        #1;
        total++;
        if (bus.rsp_overflow !== 1'b1 || bus.rsp_result !== 32'h8000_0000 || bus.rsp_zero !== 1'b0) begin
            bad++; $display("FAIL overflow: got o%b r%h want o1 r80000000", bus.rsp_overflow, bus.rsp_result);
        end
        advance();
    endtask

    task automatic test_reset_mid();
        r0 = 1'b1; r1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            total++;
            if (obs !== exp_vec()) begin
                bad++; $display("FAIL rstmid_pre%0d: got %h want %h", i, obs, exp_vec());
            end
            advance();
        end
        rst = 1'b1;
        #1;
        total++;
        if ({bus.gnt0, bus.gnt1} !== 2'b00) begin
            bad++; $display("FAIL rstmid_gnt: got %b want 00", {bus.gnt0, bus.gnt1});
        end
        advance();
        rst = 1'b0;
        #1;
        total++;
        if (bus.rsp_valid !== 1'b0 || {bus.gnt0, bus.gnt1} !== 2'b10 || obs !== exp_vec()) begin
            bad++; $display("FAIL rstmid_after: got %h want %h", obs, exp_vec());
        end
        advance();
        r0 = 1'b0; r1 = 1'b0;
        advance();
    endtask

    task automatic test_random();
        logic [1:0] g;
        logic       p0, p1;
        p0 = 1'b0; p1 = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (p0) begin
                if ($urandom_range(0, 9) == 0) r0 = 1'b0;
            end else begin
                r0 = ($urandom_range(0, 3) != 0);
                a0 = rand_opnd(); b0 = rand_opnd(); op0 = rand_op();
            end
            if (p1) begin
                if ($urandom_range(0, 9) == 0) r1 = 1'b0;
            end else begin
                r1 = ($urandom_range(0, 2) != 0);
                a1 = rand_opnd(); b1 = rand_opnd(); op1 = rand_op();
            end
            #1;
            total++;
            if (obs !== exp_vec()) begin
                bad++; $display("FAIL random%0d: got %h want %h", i, obs, exp_vec());
            end
            g = pick();
            p0 = r0 && !g[1];
            p1 = r1 && !g[0];
            advance();
        end
        r0 = 1'b0; r1 = 1'b0;
        #1;
        total++;
        if (obs !== exp_vec()) begin
            bad++; $display("FAIL random_tail: got %h want %h", obs, exp_vec());
        end
        advance();
    endtask

    initial begin
        test_reset();
        test_port0();
        test_port1();
        test_contention();
        test_withdraw();
        test_overflow();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
